// File: rtl/seg7_display_arbiter.sv
// Round-robin owner of the shared 4-digit 7-segment display.
// Enforces a minimum dwell per owner, blanks between owners and blinks the owner's digits.
module seg7_display_arbiter #(
   parameter int DWELL_CYCLES = 100_000_000,
   parameter int BLANK_CYCLES = 10_000_000,
   parameter int BLINK_HALF   = 25_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [15:0] val0,
   input  logic [15:0] val1,
   input  logic [15:0] val2,
   input  logic [3:0]  mask0,
   input  logic [3:0]  mask1,
   input  logic [3:0]  mask2,
   input  logic [2:0]  blink,
   output logic [15:0] value,
   output logic [3:0]  anode_d,
   output logic [2:0]  grant
);

   localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int GW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES - 1);
   localparam logic [GW-1:0] GAP_MAX   = GW'(BLANK_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHOW,
      BLANK
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    owner_q, owner_d;
   logic [1:0]    last_q, last_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [BW-1:0] bcnt_q;
   logic          phase_q;

   logic [1:0]    cand1, cand2;
   logic [1:0]    pick;
   logic          pick_ok;
   logic [2:0]    owner_oh;
   logic          own_req;
   logic          other_req;
   logic [15:0]   sel_val;
   logic [3:0]    sel_mask;

   function automatic logic [1:0] next3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   // Scanning last+1, last+2, then last itself gives the previous owner lowest priority.
   always_comb begin
      cand1   = next3(last_q);
      cand2   = next3(cand1);
      pick    = last_q;
      pick_ok = 1'b1;
      if (req[cand1]) begin
         pick = cand1;
      end else if (req[cand2]) begin
         pick = cand2;
      end else if (req[last_q]) begin
         pick = last_q;
      end else begin
         pick_ok = 1'b0;
      end
   end

   always_comb begin
      owner_oh  = 3'b001 << owner_q;
      own_req   = |(req & owner_oh);
      other_req = |(req & ~owner_oh);
   end

   always_comb begin
      sel_val  = val0;
      sel_mask = mask0;
      unique case (owner_q)
         2'd1: begin
            sel_val  = val1;
            sel_mask = mask1;
         end
         2'd2: begin
            sel_val  = val2;
            sel_mask = mask2;
         end
         default: begin
            sel_val  = val0;
            sel_mask = mask0;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      dwell_d = dwell_q;
      gap_d   = gap_q;
      unique case (state_q)
         IDLE: begin
            if (pick_ok) begin
               state_d = SHOW;
               owner_d = pick;
               last_d  = pick;
               dwell_d = '0;
            end
         end
         SHOW: begin
            if (!own_req) begin
               state_d = other_req ? BLANK : IDLE;
               gap_d   = '0;
            end else if (dwell_q == DWELL_MAX && other_req) begin
               state_d = BLANK;
               gap_d   = '0;
            end else if (dwell_q != DWELL_MAX) begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         BLANK: begin
            if (gap_q == GAP_MAX) begin
               if (pick_ok) begin
                  state_d = SHOW;
                  owner_d = pick;
                  last_d  = pick;
                  dwell_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= 2'd0;
         last_q  <= 2'd2;
         dwell_q <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         dwell_q <= dwell_d;
         gap_q   <= gap_d;
      end
   end

   // Blink phase runs globally so every owner sees the same cadence.
   always_ff @(posedge clk) begin
      if (rst) begin
         bcnt_q  <= '0;
         phase_q <= 1'b0;
      end else if (bcnt_q == BLINK_MAX) begin
         bcnt_q  <= '0;
         phase_q <= ~phase_q;
      end else begin
         bcnt_q <= bcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value   <= 16'h0000;
         anode_d <= 4'b1111;
         grant   <= 3'b000;
      end else if (state_q == SHOW) begin
         value   <= sel_val;
         anode_d <= (|(blink & owner_oh) && phase_q) ? 4'b1111 : sel_mask;
         grant   <= owner_oh;
      end else begin
         value   <= 16'h0000;
         anode_d <= 4'b1111;
         grant   <= 3'b000;
      end
   end

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter with short dwell, gap and blink periods.
module tb_seg7_display_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req = 3'b000;
   logic [15:0] val0 = 16'h1234;
   logic [15:0] val1 = 16'hABCD;
   logic [15:0] val2 = 16'h9876;
   logic [3:0]  mask0 = 4'b0000;
   logic [3:0]  mask1 = 4'b0101;
   logic [3:0]  mask2 = 4'b1010;
   logic [2:0]  blink = 3'b000;
   logic [15:0] value;
   logic [3:0]  anode_d;
   logic [2:0]  grant;

   int errors = 0;
   int checks = 0;

   seg7_display_arbiter #(
      .DWELL_CYCLES(8),
      .BLANK_CYCLES(2),
      .BLINK_HALF(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .val0(val0),
      .val1(val1),
      .val2(val2),
      .mask0(mask0),
      .mask1(mask1),
      .mask2(mask2),
      .blink(blink),
      .value(value),
      .anode_d(anode_d),
      .grant(grant)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 3'b000;
      step(1);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({grant, value, anode_d} !== {3'b000, 16'h0000, 4'b1111}) begin
         errors++;
         $display("FAIL reset_state got=%h/%h/%b exp=0/0000/1111", grant, value, anode_d);
      end
      val0  = 16'h1234;
      mask0 = 4'b0000;
      req   = 3'b001;
      step(1);
      checks++;
      if (grant !== 3'b000) begin
         errors++;
         $display("FAIL grant_latency got=%b exp=000", grant);
      end
      step(1);
      checks++;
      if ({grant, value, anode_d} !== {3'b001, 16'h1234, 4'b0000}) begin
         errors++;
         $display("FAIL first_grant got=%b/%h/%b exp=001/1234/0000", grant, value, anode_d);
      end
      val0 = 16'h5678;
      step(1);
      checks++;
      if (value !== 16'h5678) begin
         errors++;
         $display("FAIL live_value got=%h exp=5678", value);
      end
      rst = 1'b1;
      step(1);
      checks++;
      if ({grant, value, anode_d} !== {3'b000, 16'h0000, 4'b1111}) begin
         errors++;
         $display("FAIL reset_mid_show got=%h/%h/%b exp=0/0000/1111", grant, value, anode_d);
      end
      rst = 1'b0;
      step(2);
      checks++;
      if (grant !== 3'b001) begin
         errors++;
         $display("FAIL regrant got=%b exp=001", grant);
      end
      req = 3'b000;
      step(1);
      req = 3'b001;
      step(1);
      checks++;
      if (grant !== 3'b000) begin
         errors++;
         $display("FAIL drop_blank got=%b exp=000", grant);
      end
      step(1);
      checks++;
      if (grant !== 3'b001) begin
         errors++;
         $display("FAIL drop_no_gap got=%b exp=001", grant);
      end
      val0 = 16'h1111;
   endtask

   task automatic test_round_robin();
      logic [2:0]  eg;
      logic [15:0] ev;
      logic [3:0]  ea;
      int          o;
      do_reset();
      val0  = 16'h1111;
      val1  = 16'h2222;
      val2  = 16'h3333;
      mask0 = 4'b0001;
      mask1 = 4'b0010;
      mask2 = 4'b0100;
      req   = 3'b111;
      step(1);
      checks++;
      if (grant !== 3'b000) begin
         errors++;
         $display("FAIL rr_start got=%b exp=000", grant);
      end
      for (int j = 2; j <= 40; j++) begin
         step(1);
         o  = ((j - 2) / 10) % 3;
         eg = 3'b000;
         ev = 16'h0000;
         ea = 4'b1111;
         if ((j - 2) % 10 < 8) begin
            eg = 3'b001 << o;
            ev = (o == 0) ? 16'h1111 : (o == 1) ? 16'h2222 : 16'h3333;
            ea = (o == 0) ? 4'b0001 : (o == 1) ? 4'b0010 : 4'b0100;
         end
         checks++;
         if ({grant, value, anode_d} !== {eg, ev, ea}) begin
            errors++;
            $display("FAIL rr_seq[%0d] got=%b/%h/%b exp=%b/%h/%b",
                     j, grant, value, anode_d, eg, ev, ea);
         end
      end
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      checks++;
      if ({grant, value, anode_d} !== {3'b000, 16'h0000, 4'b1111}) begin
         errors++;
         $display("FAIL reset_mid_blank got=%b/%h/%b exp=000/0000/1111", grant, value, anode_d);
      end
      step(2);
      checks++;
      if (grant !== 3'b001) begin
         errors++;
         $display("FAIL rr_after_reset got=%b exp=001", grant);
      end
      mask0 = 4'b0000;
      mask1 = 4'b0101;
      mask2 = 4'b1010;
      val1  = 16'hABCD;
      val2  = 16'h9876;
   endtask

   task automatic test_drop_early();
      logic [2:0] exp_g [4] = '{3'b001, 3'b000, 3'b000, 3'b010};
      do_reset();
      req = 3'b011;
      step(3);
      req = 3'b010;
      for (int i = 0; i < 4; i++) begin
         step(1);
         checks++;
         if (grant !== exp_g[i]) begin
            errors++;
            $display("FAIL drop_early[%0d] got=%b exp=%b", i, grant, exp_g[i]);
         end
      end
      checks++;
      if ({value, anode_d} !== {16'hABCD, 4'b0101}) begin
         errors++;
         $display("FAIL drop_early_val got=%h/%b exp=abcd/0101", value, anode_d);
      end
   endtask

   task automatic test_saturate();
      int bad = 0;
      logic [2:0] exp_g [4] = '{3'b010, 3'b000, 3'b000, 3'b100};
      do_reset();
      req = 3'b010;
      step(1);
      for (int i = 0; i < 50; i++) begin
         step(1);
         if (grant !== 3'b010) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL sat_hold got=%0d bad cycles exp=0", bad);
      end
      req = 3'b110;
      for (int i = 0; i < 4; i++) begin
         step(1);
         checks++;
         if (grant !== exp_g[i]) begin
            errors++;
            $display("FAIL sat_handover[%0d] got=%b exp=%b", i, grant, exp_g[i]);
         end
      end
      checks++;
      if (value !== 16'h9876) begin
         errors++;
         $display("FAIL sat_value got=%h exp=9876", value);
      end
   endtask

   task automatic test_blink();
      logic [3:0] ea;
      do_reset();
      mask0 = 4'b0011;
      blink = 3'b001;
      req   = 3'b001;
      step(1);
      for (int j = 2; j <= 17; j++) begin
         step(1);
         ea = (((j - 1) / 4) % 2 == 1) ? 4'b1111 : 4'b0011;
         checks++;
         if (anode_d !== ea) begin
            errors++;
            $display("FAIL blink[%0d] got=%b exp=%b", j, anode_d, ea);
         end
      end
      blink = 3'b000;
      mask0 = 4'b0000;
   endtask

   task automatic test_back_to_back();
      do_reset();
      req = 3'b011;
      step(8);
      checks++;
      if (grant !== 3'b001) begin
         errors++;
         $display("FAIL b2b_owner0 got=%b exp=001", grant);
      end
      req = 3'b010;
      step(1);
      checks++;
      if (grant !== 3'b001) begin
         errors++;
         $display("FAIL b2b_last got=%b exp=001", grant);
      end
      step(2);
      checks++;
      if (grant !== 3'b000) begin
         errors++;
         $display("FAIL b2b_blank got=%b exp=000", grant);
      end
      step(1);
      checks++;
      if (grant !== 3'b010) begin
         errors++;
         $display("FAIL b2b_owner1 got=%b exp=010", grant);
      end
      req = 3'b001;
      step(1);
      req = 3'b000;
      for (int i = 0; i < 3; i++) begin
         step(1);
         checks++;
         if ({grant, anode_d} !== {3'b000, 4'b1111}) begin
            errors++;
            $display("FAIL b2b_idle[%0d] got=%b/%b exp=000/1111", i, grant, anode_d);
         end
      end
      req = 3'b100;
      step(2);
      checks++;
      if (grant !== 3'b100) begin
         errors++;
         $display("FAIL b2b_from_idle got=%b exp=100", grant);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_drop_early();
      test_saturate();
      test_blink();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_display_arbiter.md
# seg7_display_arbiter

Time-shares the board's single 4-digit 7-segment display between three independent requesters, such as the lab counter, a stopwatch and a status/message source. Arbitration is round-robin with a minimum dwell time per owner and a short blanking gap on every handover. The granted owner's digits can blink. Outputs drive the `value` and `anode_d` inputs of `seg7_driver` directly; the driver keeps responsibility for digit multiplexing and segment decode.

## Interface
- `DWELL_CYCLES`, default 100_000_000: minimum clocks an owner holds the display while others wait (1 s at 100 MHz); must be ≥1.
- `BLANK_CYCLES`, default 10_000_000: clocks the display is fully blanked between owners (100 ms); must be ≥1.
- `BLINK_HALF`, default 25_000_000: half-period of the blink phase in clocks; must be ≥1.
- `clk` input, 1 bit: 100 MHz system clock; all state updates on its rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `req` input, 3 bits: request per requester, level-sensitive; bit i belongs to requester i.
- `val0`, `val1`, `val2` input, 16 bits each: digits of requester i, with bits [15:12] the left digit.
- `mask0`, `mask1`, `mask2` input, 4 bits each: per-digit enable, active low (0 = digit on), with bit 3 the left digit.
- `blink` input, 3 bits: when bit i is 1 and requester i owns the display, all of its digits blink.
- `value` output, 16 bits: to `seg7_driver.value`.
- `anode_d` output, 4 bits: to `seg7_driver.anode_d`; 4'b1111 means all digits off.
- `grant` output, 3 bits: one-hot current owner; 3'b000 when no owner.

## Operation
- FSM has three states:
  - IDLE: no owner.
  - SHOW: the owner is displayed.
  - BLANK: handover gap.
- Registers: state, `owner` (2 bits), `last` (2 bits, last granted), `dwell` counter, `gap` counter, blink counter, `phase`.
- Round-robin pick: scan `last+1`, `last+2`, `last+3` (mod 3) and take the first with `req` high.
- IDLE:
  - If `req`≠0, pick the next owner and go to SHOW; set `owner` and `last`, and clear `dwell`.
  - Otherwise stay in IDLE.
- SHOW:
  - If `req[owner]`=0: go to BLANK if any other `req` bit is high, otherwise go to IDLE. The owner dropping its request takes priority over every other event in the same cycle.
  - Else if `dwell` ≥ DWELL_CYCLES−1 and another `req` bit is high: go to BLANK.
  - Else stay in SHOW. `dwell` increments and saturates at DWELL_CYCLES−1.
- BLANK:
  - `gap` counts 0..BLANK_CYCLES−1.
  - At the final count: pick the next owner from the current `req` (the previous owner is eligible only if no other requester is high) and go to SHOW. If `req`=0, go to IDLE.
  - `gap` clears on entry.
- Blink counter is free-running 0..BLINK_HALF−1. `phase` toggles on wrap.
- Registered outputs, updated every edge:
  - SHOW: `value`←`val[owner]`; `anode_d`←(`blink[owner]` & `phase`) ? 4'b1111 : `mask[owner]`; `grant`←onehot(`owner`).
  - IDLE and BLANK: `value`←16'h0000, `anode_d`←4'b1111, `grant`←3'b000.
- Values are tracked live: an owner's `val` changes appear on `value` one cycle later, with no re-arbitration.
- Reset (including mid-SHOW or mid-BLANK), taking effect at the next edge: state=IDLE, `last`=2 (so requester 0 wins first), `owner`=0, all counters 0, `phase`=0, `value`=16'h0000, `anode_d`=4'b1111, `grant`=3'b000.

## Timing
- Grant latency: with `req` rising in IDLE, the FSM samples it at edge k, and `grant`, `value` and `anode_d` are valid after edge k+1.
- Owner holds the display for at least DWELL_CYCLES clocks in SHOW before a pending competitor forces BLANK, unless it drops `req` first.
- BLANK lasts exactly BLANK_CYCLES clocks of 4'b1111.
- Owner drop with no competitor: IDLE and blank output follow after the next edge, with no gap.
- Blink: `anode_d` alternates every BLINK_HALF clocks. `phase` is global, not restarted per grant.
- Counter widths are `$clog2` of the respective parameter, minimum 1 bit. There is no overflow past the saturation or wrap points.

## Test plan
All scenarios use DWELL_CYCLES=8, BLANK_CYCLES=2, BLINK_HALF=4.
- Reset, then `req`=3'b001, `val0`=16'h1234, `mask0`=4'b0000 → `grant`=001, `value`=16'h1234, `anode_d`=4'b0000 after 2 edges. Assert `rst` for one cycle → all outputs return to their reset values.
- `req`=3'b111 held continuously → grant sequence 001, 000×2, 010, 000×2, 100, 000×2, 001, …; each nonzero grant lasts 8 clocks.
- `req`=3'b011 with owner 0; drop `req[0]` at clock 3 of SHOW → BLANK 2 clocks, then `grant`=010; no wait for the dwell.
- Only requester 1 active for 50 clocks → `grant`=010 stays the whole time and `dwell` saturates; raise `req[2]` → BLANK starts the next cycle.
- `blink[0]`=1 with owner 0, `mask0`=4'b0011 → `anode_d` alternates 4'b0011 / 4'b1111 every 4 clocks.
- `req[0]` drops in the same cycle dwell expires, with `req[1]` high → BLANK, then owner 1. Then drop all `req` during BLANK → IDLE, `grant`=000.
